// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution sequencer.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_X_DEF     = 5;
  localparam int ADDR_Y_DEF     = 5;
  localparam int ADDR_Z_DEF     = 6;
  localparam int ZW_DEF         = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    MAC,
    WRITE,
    DONE
  } conv_state_t;

  // Wide enough for min(SX,SY) full products, so the sum can never overflow.
  function automatic int acc_width(input int dw, input int ax, input int ay);
    return 2 * dw + ((ax < ay) ? ax : ay) + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate register with clear/enable and the Z output stage.
// Build option CONV_SAT_EN: saturate the result to ZW bits instead of wrapping.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_X     = ADDR_X_DEF,
  parameter int ADDR_Y     = ADDR_Y_DEF,
  parameter int ZW         = ZW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ZW-1:0]         z
);

  localparam int AW = acc_width(DATA_WIDTH, ADDR_X, ADDR_Y);

  logic [AW-1:0]           acc;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

`ifdef CONV_SAT_EN
  assign z = (|acc[AW-1:ZW]) ? {ZW{1'b1}} : acc[ZW-1:0];
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[AW-1:ZW];
  assign z = acc[ZW-1:0];
`endif

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks z[i] = sum_k x[k]*y[i-k] over memories X/Y and writes Z.
// Build option CONV_SAT_EN (in conv_mac) selects saturating result words.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_X     = ADDR_X_DEF,
  parameter int ADDR_Y     = ADDR_Y_DEF,
  parameter int ADDR_Z     = ADDR_Z_DEF,
  parameter int ZW         = ZW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_X:0]       size_x,
  input  logic [ADDR_Y:0]       size_y,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_X-1:0]     x_addr,
  output logic                  x_re,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  output logic [ADDR_Y-1:0]     y_addr,
  output logic                  y_re,
  input  logic [DATA_WIDTH-1:0] y_rdata,
  output logic [ADDR_Z-1:0]     z_addr,
  output logic                  z_we,
  output logic [ZW-1:0]         z_wdata
);

  // Index arithmetic width: holds SX+SY, the largest intermediate.
  localparam int CW = ADDR_Z + 1;

  conv_state_t     state;
  logic [ADDR_X:0] sx;
  logic [ADDR_Y:0] sy;
  logic [CW-1:0]   i, k, klast;
  logic [CW-1:0]   sx_w, sy_w, k_first, k_last, last_i;

  assign sx_w    = CW'(sx);
  assign sy_w    = CW'(sy);
  assign k_first = (i + CW'(1) >= sy_w) ? (i + CW'(1) - sy_w) : '0;
  assign k_last  = (i < sx_w - CW'(1)) ? i : (sx_w - CW'(1));
  assign last_i  = sx_w + sy_w - CW'(2);

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_X    (ADDR_X),
    .ADDR_Y    (ADDR_Y),
    .ZW        (ZW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == SETUP),
    .en   (state == MAC),
    .a    (x_rdata),
    .b    (y_rdata),
    .z    (z_wdata)
  );

  // Outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      x_re   <= 1'b0;
      y_re   <= 1'b0;
      z_we   <= 1'b0;
      x_addr <= '0;
      y_addr <= '0;
      z_addr <= '0;
      sx     <= '0;
      sy     <= '0;
      i      <= '0;
      k      <= '0;
      klast  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sx <= size_x;
            sy <= size_y;
            i  <= '0;
            if (size_x == '0 || size_y == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
              busy  <= 1'b1;
            end
          end
        end
        SETUP: begin
          k      <= k_first;
          klast  <= k_last;
          x_addr <= ADDR_X'(k_first);
          y_addr <= ADDR_Y'(i - k_first);
          x_re   <= 1'b1;
          y_re   <= 1'b1;
          state  <= READ;
        end
        READ: begin
          x_re  <= 1'b0;
          y_re  <= 1'b0;
          state <= MAC;
        end
        MAC: begin
          if (k == klast) begin
            z_addr <= ADDR_Z'(i);
            z_we   <= 1'b1;
            state  <= WRITE;
          end else begin
            k      <= k + CW'(1);
            x_addr <= ADDR_X'(k + CW'(1));
            y_addr <= ADDR_Y'(i - k - CW'(1));
            x_re   <= 1'b1;
            y_re   <= 1'b1;
            state  <= READ;
          end
        end
        WRITE: begin
          z_we <= 1'b0;
          if (i == last_i) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + CW'(1);
            state <= SETUP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: memory models, reference convolution, Z-write scoreboard.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int DW = 8;
  localparam int AX = 5;
  localparam int AY = 5;
  localparam int AZ = 6;
  localparam int ZW = 16;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic [AX:0]   size_x = '0;
  logic [AY:0]   size_y = '0;
  logic          busy, done, x_re, y_re, z_we;
  logic [AX-1:0] x_addr;
  logic [AY-1:0] y_addr;
  logic [AZ-1:0] z_addr;
  logic [ZW-1:0] z_wdata;
  logic [DW-1:0] x_rdata = '0;
  logic [DW-1:0] y_rdata = '0;

  logic [DW-1:0] xmem [32];
  logic [DW-1:0] ymem [32];

  typedef struct {
    logic [AZ-1:0] addr;
    logic [ZW-1:0] data;
  } zexp_t;
  zexp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [36:0] outs;
  assign outs = {busy, done, x_re, y_re, z_we, x_addr, y_addr, z_addr, z_wdata};

  conv_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .size_x (size_x),
    .size_y (size_y),
    .busy   (busy),
    .done   (done),
    .x_addr (x_addr),
    .x_re   (x_re),
    .x_rdata(x_rdata),
    .y_addr (y_addr),
    .y_re   (y_re),
    .y_rdata(y_rdata),
    .z_addr (z_addr),
    .z_we   (z_we),
    .z_wdata(z_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (x_re) x_rdata <= xmem[x_addr];
    if (y_re) y_rdata <= ymem[y_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int sx, input int sy);
    zexp_t  e;
    longint s;
    if (sx == 0 || sy == 0) return;
    for (int ii = 0; ii <= sx + sy - 2; ii++) begin
      s = 0;
      for (int kk = 0; kk < sx; kk++)
        if (ii - kk >= 0 && ii - kk < sy)
          s += longint'(xmem[kk]) * longint'(ymem[ii - kk]);
`ifdef CONV_SAT_EN
      if (s > 65535) s = 65535;
`endif
      e.addr = AZ'(ii);
      e.data = s[ZW-1:0];
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the budget ran out).
  task automatic run_job(input int sx, input int sy, input bit keep_start, input bit disturb);
    int    busy_cnt = 0, re_cnt = 0, we_cnt = 0, cyc = 0, exp_busy;
    bit    seen_done = 0;
    bit    zero_job;
    zexp_t e;
    zero_job = (sx == 0 || sy == 0);
    exp_busy = zero_job ? 0 : 2 * sx * sy + 2 * (sx + sy - 1);
    push_expected(sx, sy);
    size_x = (AX+1)'(sx);
    size_y = (AY+1)'(sy);
    start  = 1'b1;
    while (!seen_done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (!keep_start) start = 1'b0;
      if (disturb && cyc == 7) begin
        start  = 1'b0;
        size_x = 6'd2;
        size_y = 6'd9;
      end
      if (disturb && cyc == 9) start = 1'b1;
      if (busy) busy_cnt++;
      if (x_re) re_cnt++;
      if (x_re !== y_re) chk("re_pair", y_re, x_re);
      if (z_we) begin
        we_cnt++;
        if (sb.size() == 0) chk("z_extra_write", 1, 0);
        else begin
          e = sb.pop_front();
          chk("z_addr", z_addr, e.addr);
          chk("z_data", z_wdata, e.data);
        end
      end
      if (done) begin
        seen_done = 1;
        chk("busy_in_done", busy, 0);
      end
    end
    chk("done_seen", seen_done, 1);
    chk("done_latency", cyc, exp_busy + 1);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("read_count", re_cnt, sx * sy);
    chk("write_count", we_cnt, zero_job ? 0 : sx + sy - 1);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
    if (!keep_start) begin
      @(negedge clk);
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int  rd, wr, cnt;
    bit  hit;

    for (int n = 0; n < 32; n++) begin
      xmem[n] = '0;
      ymem[n] = '0;
    end

    #3;
    chk("reset_outputs", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs, 0);

    // Test 1: {1,2,3} * {1,1}
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd1; ymem[1] = 8'd1;
    run_job(3, 2, 0, 0);

    // Test 2: single sample each
    xmem[0] = 8'd5; ymem[0] = 8'd7;
    run_job(1, 1, 0, 0);

    // Test 3: empty operand sets touch no memory
    run_job(0, 4, 0, 0);
    run_job(4, 0, 0, 0);

    // Random operands, unequal sizes
    for (int n = 0; n < 32; n++) begin
      xmem[n] = DW'($urandom_range(0, 255));
      ymem[n] = DW'($urandom_range(0, 255));
    end
    run_job(5, 7, 0, 0);
    run_job(9, 2, 0, 0);

    // Test 4: full-size all-ones (wrap or saturate on z[31])
    for (int n = 0; n < 32; n++) begin
      xmem[n] = 8'hFF;
      ymem[n] = 8'hFF;
    end
    run_job(32, 32, 0, 0);

    // Test 5: start held and re-pulsed mid-job, sizes disturbed
    xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
    ymem[0] = 8'd1; ymem[1] = 8'd1;
    run_job(3, 2, 1, 1);
    @(negedge clk);
    chk("rejob_idle_gap", busy, 0);
    @(negedge clk);
    chk("rejob_accept", busy, 1);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (done) hit = 1;
    end
    chk("rejob_done", hit, 1);
    @(negedge clk);

    // Test 6: reset during the third MAC of test 1
    size_x = 6'd3;
    size_y = 6'd2;
    start  = 1'b1;
    rd = 0; wr = 0; hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (z_we) wr++;
      if (x_re) begin
        rd++;
        if (rd == 3) hit = 1;
      end
    end
    chk("abort_reach_read3", hit, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_async_outputs", outs, 0);
    chk("abort_writes_before", wr, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_job(3, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
